// File: rtl/mode_pkg.sv
// mode_pkg: width helpers and the home mode index.
// Shared by the sequencer, its debouncer and its bus interface.
package mode_pkg;

    localparam int unsigned MODE_HOME = 0;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned v;
        int unsigned r;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v != 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int unsigned mode_w(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max);
        return mode_w(max + 1);
    endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// mode_sequencer_if: board-side button, per-mode buses and muxed outputs.
// master drives button/mode buses, slave is the sequencer.
interface mode_sequencer_if
    import mode_pkg::*;
#(
    parameter int unsigned NUM_MODES = 3,
    parameter int unsigned SEG_W     = 64,
    parameter int unsigned LED_W     = 16,
    parameter int unsigned MW        = mode_w(NUM_MODES)
);
    logic                       mode_btn;
    logic [NUM_MODES*SEG_W-1:0] seg_in;
    logic [NUM_MODES*LED_W-1:0] led_in;
    logic [NUM_MODES-1:0]       beep_in;
    logic [MW-1:0]              mode;
    logic [NUM_MODES-1:0]       mode_oh;
    logic [NUM_MODES-1:0]       sub_rst;
    logic [SEG_W-1:0]           seg_out;
    logic [LED_W-1:0]           led_out;
    logic                       beep_out;

    modport master (
        output mode_btn, seg_in, led_in, beep_in,
        input  mode, mode_oh, sub_rst,
        input  seg_out, led_out, beep_out
    );

    modport slave (
        input  mode_btn, seg_in, led_in, beep_in,
        output mode, mode_oh, sub_rst,
        output seg_out, led_out, beep_out
    );
endinterface

// File: rtl/mode_sequencer_btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stable-level counter.
// A level is accepted after DEB_CYCLES consecutive differing samples.
module btn_debounce
    import mode_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);
    localparam int unsigned CW = cnt_w(DEB_CYCLES);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // Synchronise, count mismatching samples, accept and pulse on a new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1   <= i_btn;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_cnt    <= '0;
                r_stable <= r_s2;
                r_rise   <= r_s2;
                r_fall   <= ~r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: button-driven mode cycler with blanking and output mux.
// MODE_LONGPRESS_EN: advance on short release, long press jumps home.
module mode_sequencer
    import mode_pkg::*;
#(
    parameter int unsigned NUM_MODES   = 3,
    parameter int unsigned SEG_W       = 64,
    parameter int unsigned LED_W       = 16,
    parameter int unsigned DEB_CYCLES  = 20000,
    parameter int unsigned RST_HOLD    = 8,
    parameter int unsigned LONG_CYCLES = 2000000
) (
    input  logic            clk,
    input  logic            rst,
    mode_sequencer_if.slave bus
);
    localparam int unsigned MW = mode_w(NUM_MODES);
    localparam int unsigned HW = cnt_w(RST_HOLD);

    logic [MW-1:0]        r_mode;
    logic [HW-1:0]        r_hold;
    logic [SEG_W-1:0]     r_seg;
    logic [LED_W-1:0]     r_led;
    logic                 r_beep;
    logic [SEG_W-1:0]     w_seg;
    logic [LED_W-1:0]     w_led;
    logic                 w_beep;
    logic [NUM_MODES-1:0] w_oh;
    logic                 w_stable;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_adv;
    logic                 w_home;
    logic                 w_blank;
    logic                 w_last;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.mode_btn),
        .o_stable(w_stable),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

`ifdef MODE_LONGPRESS_EN
    localparam int unsigned PW = cnt_w(LONG_CYCLES);

    logic [PW-1:0] r_press;
    logic          r_ldone;
    logic          w_unused;

    assign w_home   = w_stable && (r_press == PW'(LONG_CYCLES - 1));
    assign w_adv    = w_fall && !r_ldone && !w_home;
    assign w_unused = w_rise;

    // Time the held press (saturating) and remember a long press until release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_press <= '0;
            r_ldone <= 1'b0;
        end else begin
            if (!w_stable) begin
                r_press <= '0;
            end else if (r_press != PW'(LONG_CYCLES)) begin
                r_press <= r_press + 1'b1;
            end
            if (w_fall) begin
                r_ldone <= 1'b0;
            end else if (w_home) begin
                r_ldone <= 1'b1;
            end
        end
    end
`else
    logic w_unused;

    assign w_home   = 1'b0;
    assign w_adv    = w_rise;
    assign w_unused = w_stable ^ w_fall ^ (LONG_CYCLES == 0);
`endif

    assign w_last  = (r_mode == MW'(NUM_MODES - 1));
    assign w_blank = (r_hold != '0);

    // Mode register and blanking counter; events during blanking are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MW'(MODE_HOME);
            r_hold <= HW'(RST_HOLD);
        end else if (w_home) begin
            r_mode <= MW'(MODE_HOME);
            r_hold <= HW'(RST_HOLD);
        end else if (w_blank) begin
            r_hold <= r_hold - 1'b1;
        end else if (w_adv) begin
            r_mode <= w_last ? MW'(MODE_HOME) : r_mode + 1'b1;
            r_hold <= HW'(RST_HOLD);
        end
    end

    // Select the active mode's slice and build the one-hot.
    always_comb begin
        w_seg  = '0;
        w_led  = '0;
        w_beep = 1'b0;
        w_oh   = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (r_mode == MW'(m)) begin
                w_seg   = bus.seg_in[m*SEG_W +: SEG_W];
                w_led   = bus.led_in[m*LED_W +: LED_W];
                w_beep  = bus.beep_in[m];
                w_oh[m] = 1'b1;
            end
        end
    end

    // Register the selected slice so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg  <= '0;
            r_led  <= '0;
            r_beep <= 1'b0;
        end else begin
            r_seg  <= w_seg;
            r_led  <= w_led;
            r_beep <= w_beep;
        end
    end

    assign bus.mode     = r_mode;
    assign bus.mode_oh  = w_oh;
    assign bus.sub_rst  = w_blank ? '1 : ~w_oh;
    assign bus.seg_out  = w_blank ? '0 : r_seg;
    assign bus.led_out  = w_blank ? '0 : r_led;
    assign bus.beep_out = w_blank ? 1'b0 : r_beep;
endmodule
